// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types and defaults (reset PC, ROM error word, state enum, queue entry)
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h00400000;
  localparam logic [31:0] ERR_WORD_DEF = 32'hDEADBEEF;
  typedef enum logic {RUN, HALT} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: sync FIFO of fetch entries; ports clk/rst, push/pop/flush (flush wins), din, head, full, empty
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  assign head  = mem[rptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push && !flush) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC + ROM fetch into a small queue; ports clk/rst, imem_addr/imem_rd, redirect_valid/pc, out_valid/ready/instr/pc/pc_plus4, fetch_fault
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fetch_fault
);
  fetch_state_t state;
  fetch_entry_t head;
  logic [31:0] pc;
  logic full, empty, pop, try_fetch, fetch_ok, push, fault;
  assign imem_addr    = pc;
  assign out_valid    = !empty && !rst;
  assign pop          = out_valid && out_ready;
  assign try_fetch    = state == RUN && !redirect_valid && (!full || pop);
  assign fetch_ok     = pc[1:0] == 2'b00 && imem_rd != ERR_WORD;
  assign push         = try_fetch && fetch_ok;
  assign fault        = try_fetch && !fetch_ok;
  assign out_instr    = out_valid ? head.instr : '0;
  assign out_pc       = out_valid ? head.pc : '0;
  assign out_pc_plus4 = out_valid ? head.pc + 32'd4 : '0;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ('{pc: pc, instr: imem_rd}),
    .head (head),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= RUN;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      state       <= RUN;
      fetch_fault <= 1'b0;
    end else if (push) begin
      pc <= pc + 32'd4;
    end else if (fault) begin
      state       <= HALT;
      fetch_fault <= 1'b1;
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the combinational instruction ROM. It owns the program counter, drives the ROM address, and captures each returned word together with its PC into a 2-entry queue. The queue presents entries to decode over a valid/ready handshake. It handles branch/jump redirects by flushing the queue, and it halts fetch on the ROM's error word or on a misaligned target.

Parameters:
RESET_PC, 32'h00400000, PC loaded on reset (text-segment base)
DEPTH, 2, fetch-queue entries (power of 2, >=2)
ERR_WORD, 32'hDEADBEEF, ROM word that signals an unmapped address

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  32  ROM address; always equals current PC register
imem_rd  in  32  ROM data; combinational from imem_addr, same cycle
redirect_valid  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  32  redirect target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction word
out_pc  out  32  head PC
out_pc_plus4  out  32  head PC + 4
fetch_fault  out  1  sticky: fetch halted on error word or misaligned target

Behaviour:
- Reset is synchronous: on a clk edge with rst=1 the block sets pc=RESET_PC, empties the queue, sets state=RUN and clears fetch_fault. rst overrides all other inputs.
- Outputs while in reset or with the queue empty: out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0.
- States (fetch_state_t): RUN and HALT.
- Definitions: pop = out_valid & out_ready; full = (count==DEPTH).
- push = state==RUN & !redirect_valid & (!full | pop) & pc[1:0]==0 & imem_rd!=ERR_WORD.
- On push: enqueue {pc, imem_rd} and set pc <= pc+4. Arithmetic is 32-bit modulo, so 32'hFFFFFFFC wraps to 0.
- Latency: a word fetched in cycle N appears at the head with out_valid=1 in cycle N+1 if the queue was empty. With the consumer always ready, throughput is 1 instruction/cycle.
- Full queue, no pop: no push, pc holds, imem_addr stable.
- Full queue with pop in the same cycle: push and pop both occur, count is unchanged.
- Empty queue: out_valid=0. A pop cannot occur.
- RUN -> HALT when imem_rd==ERR_WORD and the queue has room (or a pop frees it):
  - the error word is not enqueued; pc holds;
  - fetch_fault=1 from the next cycle;
  - entries already queued still drain normally.
- RUN -> HALT when pc[1:0]!=0 at fetch time: same actions as the error-word case.
- HALT: no pushes. fetch_fault stays 1. Only redirect_valid or rst leaves HALT.
- Redirect (redirect_valid=1), in any state:
  - the queue is flushed at the edge, so out_valid=0 next cycle;
  - pc <= redirect_pc;
  - state <= RUN and fetch_fault <= 0;
  - no push that cycle;
  - a misaligned redirect_pc faults on the following cycle.
- Redirect and pop in the same cycle: the pop counts as a completed transfer, and the flush still empties every remaining entry. Redirect has priority over push.
- out_pc_plus4 = out_pc + 4, computed combinationally from the head entry.
- Queue pointers wrap modulo DEPTH. count has range 0..DEPTH.

Decomposition:
- fetch_pkg contains:
  - localparams RESET_PC_DEF and ERR_WORD_DEF;
  - typedef enum logic {RUN, HALT} fetch_state_t;
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and head outputs; flush has priority over push.
- fetch_unit instantiates fetch_queue and holds the PC register, state register and push/fault logic.

Test Plan:
- Reset then out_ready=1 for 8 cycles, ROM model returning pc^32'h1000 -> heads in order 0x00400000..0x0040001C with matching instr, one per cycle, first out_valid one cycle after rst falls.
- out_ready=0 for 5 cycles from reset -> queue fills with PCs 0x00400000 and 0x00400004, imem_addr stalls at 0x00400008; release ready -> 0x00400008 appears third, nothing lost or duplicated.
- Redirect to 0x00400040 while the queue holds 2 entries and pop=1 -> next cycle out_valid=0; following cycle head pc=0x00400040; stale entries never appear.
- ROM returns 32'hDEADBEEF at 0x0040000C -> the 3 prior words drain, fetch_fault=1, out_valid drops, imem_addr holds 0x0040000C; a redirect to 0x00400000 clears the fault and resumes.
- Redirect to 0x00400002 -> next cycle HALT with fetch_fault=1 and no entry enqueued.
- rst asserted mid-stream with a full queue -> next cycle out_valid=0, imem_addr=0x00400000, fetch_fault=0.
